// File: rtl/b_powermonitor_pkg.sv
// Shared definitions for the power monitor UDB back end: FSM encoding,
// aggregation modes and the channel-count ceiling.
package b_powermonitor_pkg;

  localparam int unsigned MAX_CONVERTERS = 32;

  localparam int unsigned PGOOD_OR  = 0;
  localparam int unsigned PGOOD_AND = 1;
  localparam int unsigned PGOOD_BUS = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_POWER_UP = 2'd1,
    ST_GOOD     = 2'd2,
    ST_FAULT    = 2'd3
  } pm_state_e;

  function automatic logic [MAX_CONVERTERS-1:0] active_mask(input int unsigned n);
    logic [MAX_CONVERTERS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_CONVERTERS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/b_powermonitor_debounce.sv
// Single-channel pgood filter: the output follows the input only after
// DebounceCycles consecutive samples that disagree with it.
module b_powermonitor_debounce #(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_filt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (i_raw == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CntW'(DebounceCycles - 1)) begin
      r_filt <= i_raw;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/b_powermonitor_v2.sv
// Power monitor back end: per-channel debounce, pgood aggregation,
// power-up supervisor FSM, sticky fault/warn/timeout flags and EOC pulse.
module b_powermonitor_v2
  import b_powermonitor_pkg::*;
#(
  parameter int unsigned NumConverters  = 1,
  parameter int unsigned PgoodConfig    = 0,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned TimeoutCycles  = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pgood_raw,
  input  logic        ctl_warn,
  input  logic        ctl_fault,
  input  logic        ctl_eoc,
  input  logic        ctl_start,
  input  logic        ctl_clear,
  output logic        fault,
  output logic        warn,
  output logic        eoc,
  output logic [31:0] pgood_bus,
  output logic [1:0]  state,
  output logic        timeout
);

  localparam int unsigned TimerW = 16;
  localparam logic [MAX_CONVERTERS-1:0] ActiveMask = active_mask(NumConverters);

  logic [MAX_CONVERTERS-1:0] w_filt;
  logic [MAX_CONVERTERS-1:0] w_bus_d;
  logic                      w_all_good;

  pm_state_e         r_state;
  pm_state_e         w_state_nxt;
  logic [TimerW-1:0] r_timer;
  logic              w_timer_load;
  logic              w_enter_fault;
  logic              w_set_timeout;

  logic [31:0] r_bus;
  logic        r_fault;
  logic        r_warn;
  logic        r_timeout;
  logic        r_eoc;
  logic        r_eoc_hist;

  // Inactive channels are tied low so every reduction below sees only real converters.
  genvar g;
  generate
    for (g = 0; g < MAX_CONVERTERS; g++) begin : g_ch
      if (g < NumConverters) begin : g_active
        b_powermonitor_debounce #(
          .DebounceCycles(DebounceCycles)
        ) u_deb (
          .i_clock  (clock),
          .i_reset_n(reset_n),
          .i_raw    (pgood_raw[g]),
          .o_filt   (w_filt[g])
        );
      end else begin : g_idle
        logic w_unused_raw;
        assign w_unused_raw = pgood_raw[g];
        assign w_filt[g]    = 1'b0;
      end
    end
  endgenerate

  assign w_all_good = &(w_filt | ~ActiveMask);

  always_comb begin
    w_bus_d = '0;
    case (PgoodConfig)
      PGOOD_OR:  w_bus_d[0] = |w_filt;
      PGOOD_AND: w_bus_d[0] = w_all_good;
      default:   w_bus_d    = w_filt;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_bus <= '0;
    else          r_bus <= w_bus_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Clear overrides every transition; good beats timeout in POWER_UP.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_load  = 1'b0;
    w_enter_fault = 1'b0;
    w_set_timeout = 1'b0;
    if (ctl_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctl_start) begin
            w_state_nxt  = ST_POWER_UP;
            w_timer_load = 1'b1;
          end
        end
        ST_POWER_UP: begin
          if (w_all_good) begin
            w_state_nxt = ST_GOOD;
          end else if (r_timer == TimerW'(TimeoutCycles - 1)) begin
            w_state_nxt   = ST_FAULT;
            w_enter_fault = 1'b1;
            w_set_timeout = 1'b1;
          end
        end
        ST_GOOD: begin
          if (!w_all_good) begin
            w_state_nxt   = ST_FAULT;
            w_enter_fault = 1'b1;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   r_timer <= '0;
    else if (w_timer_load)          r_timer <= '0;
    else if (r_state == ST_POWER_UP) r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fault   <= 1'b0;
      r_warn    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (ctl_fault || w_enter_fault) r_fault <= 1'b1;
      else if (ctl_clear)             r_fault <= 1'b0;

      if (ctl_warn)       r_warn <= 1'b1;
      else if (ctl_clear) r_warn <= 1'b0;

      if (w_set_timeout)  r_timeout <= 1'b1;
      else if (ctl_clear) r_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_eoc_hist <= 1'b0;
      r_eoc      <= 1'b0;
    end else begin
      r_eoc_hist <= ctl_eoc;
      r_eoc      <= ctl_eoc ^ r_eoc_hist;
    end
  end

  assign fault     = r_fault;
  assign warn      = r_warn;
  assign timeout   = r_timeout;
  assign eoc       = r_eoc;
  assign pgood_bus = r_bus;
  assign state     = r_state;

endmodule

// File: tb/tb_b_powermonitor_v2.sv
// Bench for b_powermonitor_v2: four instances (N=3 bus mode, N=5 in OR/AND/bus
// modes) share stimulus; directed sequences plus a history-based reference model.
module tb_b_powermonitor_v2;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int NI  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pgood_raw = '0;
  logic        ctl_warn = 1'b0;
  logic        ctl_fault = 1'b0;
  logic        ctl_eoc = 1'b0;
  logic        ctl_start = 1'b0;
  logic        ctl_clear = 1'b0;

  logic        fault_w   [NI];
  logic        warn_w    [NI];
  logic        eoc_w     [NI];
  logic        timeout_w [NI];
  logic [1:0]  st_w      [NI];
  logic [31:0] bus_w     [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  b_powermonitor_v2 #(.NumConverters(3), .PgoodConfig(2), .DebounceCycles(DEB), .TimeoutCycles(TMO)) u_a (
    .clock(clock), .reset_n(reset_n), .pgood_raw(pgood_raw), .ctl_warn(ctl_warn),
    .ctl_fault(ctl_fault), .ctl_eoc(ctl_eoc), .ctl_start(ctl_start), .ctl_clear(ctl_clear),
    .fault(fault_w[0]), .warn(warn_w[0]), .eoc(eoc_w[0]), .pgood_bus(bus_w[0]),
    .state(st_w[0]), .timeout(timeout_w[0]));

  b_powermonitor_v2 #(.NumConverters(5), .PgoodConfig(0), .DebounceCycles(DEB), .TimeoutCycles(TMO)) u_m0 (
    .clock(clock), .reset_n(reset_n), .pgood_raw(pgood_raw), .ctl_warn(ctl_warn),
    .ctl_fault(ctl_fault), .ctl_eoc(ctl_eoc), .ctl_start(ctl_start), .ctl_clear(ctl_clear),
    .fault(fault_w[1]), .warn(warn_w[1]), .eoc(eoc_w[1]), .pgood_bus(bus_w[1]),
    .state(st_w[1]), .timeout(timeout_w[1]));

  b_powermonitor_v2 #(.NumConverters(5), .PgoodConfig(1), .DebounceCycles(DEB), .TimeoutCycles(TMO)) u_m1 (
    .clock(clock), .reset_n(reset_n), .pgood_raw(pgood_raw), .ctl_warn(ctl_warn),
    .ctl_fault(ctl_fault), .ctl_eoc(ctl_eoc), .ctl_start(ctl_start), .ctl_clear(ctl_clear),
    .fault(fault_w[2]), .warn(warn_w[2]), .eoc(eoc_w[2]), .pgood_bus(bus_w[2]),
    .state(st_w[2]), .timeout(timeout_w[2]));

  b_powermonitor_v2 #(.NumConverters(5), .PgoodConfig(2), .DebounceCycles(DEB), .TimeoutCycles(TMO)) u_m2 (
    .clock(clock), .reset_n(reset_n), .pgood_raw(pgood_raw), .ctl_warn(ctl_warn),
    .ctl_fault(ctl_fault), .ctl_eoc(ctl_eoc), .ctl_start(ctl_start), .ctl_clear(ctl_clear),
    .fault(fault_w[3]), .warn(warn_w[3]), .eoc(eoc_w[3]), .pgood_bus(bus_w[3]),
    .state(st_w[3]), .timeout(timeout_w[3]));

  int NV [NI] = '{3, 5, 5, 5};
  int MD [NI] = '{2, 0, 1, 2};

  // Filter modelled as "last DEB raw samples all disagree with filt".
  typedef struct packed {
    logic [31:0]      filt;
    logic [31:0][3:0] hist;
    logic [31:0]      bus;
    logic [1:0]       st;
    logic [15:0]      pu_cycles;
    logic             fault;
    logic             warn;
    logic             timeout;
    logic             eoc;
    logic             eoc_prev;
  } model_t;

  model_t m [NI];

  function automatic model_t step(input model_t cur, input int n, input int mode,
                                  input logic [31:0] raw, input logic start, input logic clr,
                                  input logic w, input logic f, input logic e);
    model_t      r;
    logic [31:0] mask;
    logic        all_good;
    logic        enter_f;
    logic        set_to;
    r = cur;
    mask = '0;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    all_good = ((cur.filt & mask) == mask);
    for (int i = 0; i < 32; i++) begin
      r.hist[i] = {cur.hist[i][2:0], raw[i]};
      if (mask[i] && r.hist[i] == {4{~cur.filt[i]}}) r.filt[i] = ~cur.filt[i];
    end
    r.bus = '0;
    if (mode == 0)      r.bus[0] = |(cur.filt & mask);
    else if (mode == 1) r.bus[0] = all_good;
    else                r.bus = cur.filt & mask;
    enter_f = 1'b0;
    set_to  = 1'b0;
    if (clr) r.st = 2'd0;
    else if (cur.st == 2'd0) begin
      if (start) begin r.st = 2'd1; r.pu_cycles = '0; end
    end else if (cur.st == 2'd1) begin
      r.pu_cycles = cur.pu_cycles + 16'd1;
      if (all_good) r.st = 2'd2;
      else if (int'(cur.pu_cycles) + 1 == TMO) begin r.st = 2'd3; enter_f = 1'b1; set_to = 1'b1; end
    end else if (cur.st == 2'd2) begin
      if (!all_good) begin r.st = 2'd3; enter_f = 1'b1; end
    end
    r.fault   = (f || enter_f) ? 1'b1 : (clr ? 1'b0 : cur.fault);
    r.warn    = w ? 1'b1 : (clr ? 1'b0 : cur.warn);
    r.timeout = set_to ? 1'b1 : (clr ? 1'b0 : cur.timeout);
    r.eoc      = e ^ cur.eoc_prev;
    r.eoc_prev = e;
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NI; k++) m[k] <= '0;
    end else begin
      for (int k = 0; k < NI; k++)
        m[k] <= step(m[k], NV[k], MD[k], pgood_raw, ctl_start, ctl_clear, ctl_warn, ctl_fault, ctl_eoc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("model%0d_bus", k),     bus_w[k],            m[k].bus);
        chk($sformatf("model%0d_state", k),   32'(st_w[k]),        32'(m[k].st));
        chk($sformatf("model%0d_fault", k),   32'(fault_w[k]),     32'(m[k].fault));
        chk($sformatf("model%0d_warn", k),    32'(warn_w[k]),      32'(m[k].warn));
        chk($sformatf("model%0d_timeout", k), 32'(timeout_w[k]),   32'(m[k].timeout));
        chk($sformatf("model%0d_eoc", k),     32'(eoc_w[k]),       32'(m[k].eoc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] raw;
    logic [31:0] e_or;
    logic [31:0] e_and;
    logic [31:0] e_bus5;
    logic [31:0] e_bus3;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{32'hFFFF_FFF4, 32'h1, 32'h0, 32'h14, 32'h4};
    vt[1] = '{32'h0000_001F, 32'h1, 32'h1, 32'h1F, 32'h7};
    vt[2] = '{32'h0000_0000, 32'h0, 32'h0, 32'h00, 32'h0};
    vt[3] = '{32'hFFFF_FFE1, 32'h1, 32'h0, 32'h01, 32'h1};
    vt[4] = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'h1F, 32'h7};

    repeat (3) tick();
    chk("rst_state", 32'(st_w[0]), 32'd0);
    chk("rst_fault", 32'(fault_w[0]), 32'd0);
    chk("rst_warn", 32'(warn_w[0]), 32'd0);
    chk("rst_timeout", 32'(timeout_w[0]), 32'd0);
    chk("rst_eoc", 32'(eoc_w[0]), 32'd0);
    chk("rst_bus_and", bus_w[2], 32'd0);
    reset_n = 1'b1;
    tick();

    // Glitch of DEB-1 cycles on channel 2, then a held change.
    pgood_raw = 32'h4;
    repeat (3) tick();
    pgood_raw = 32'h0;
    repeat (3) tick();
    chk("glitch_bus", bus_w[3], 32'h0);
    pgood_raw = 32'h4;
    repeat (3) tick();
    chk("hold3_bus", bus_w[3], 32'h0);
    tick();
    chk("hold4_bus", bus_w[3], 32'h0);
    tick();
    chk("hold5_bus", bus_w[3], 32'h4);
    chk("hold5_bus_n3", bus_w[0], 32'h4);
    pgood_raw = 32'h0;
    repeat (6) tick();

    for (int v = 0; v < 5; v++) begin
      pgood_raw = vt[v].raw;
      repeat (6) tick();
      chk($sformatf("vec%0d_or", v),   bus_w[1], vt[v].e_or);
      chk($sformatf("vec%0d_and", v),  bus_w[2], vt[v].e_and);
      chk($sformatf("vec%0d_bus5", v), bus_w[3], vt[v].e_bus5);
      chk($sformatf("vec%0d_bus3", v), bus_w[0], vt[v].e_bus3);
    end
    pgood_raw = 32'h0;
    repeat (6) tick();

    // Power-up success on the N=3 instance.
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
    chk("pu_enter", 32'(st_w[0]), 32'd1);
    repeat (4) tick();
    pgood_raw = 32'h7;
    repeat (4) tick();
    chk("pu_wait", 32'(st_w[0]), 32'd1);
    tick();
    chk("pu_good", 32'(st_w[0]), 32'd2);
    chk("pu_fault", 32'(fault_w[0]), 32'd0);
    chk("pu_timeout", 32'(timeout_w[0]), 32'd0);

    // Loss of good: short drop ignored, long drop faults.
    pgood_raw = 32'h6;
    repeat (3) tick();
    pgood_raw = 32'h7;
    repeat (4) tick();
    chk("drop_short", 32'(st_w[0]), 32'd2);
    pgood_raw = 32'h6;
    repeat (4) tick();
    chk("drop_long4", 32'(st_w[0]), 32'd2);
    tick();
    chk("drop_long5", 32'(st_w[0]), 32'd3);
    chk("drop_fault", 32'(fault_w[0]), 32'd1);
    chk("drop_timeout", 32'(timeout_w[0]), 32'd0);
    ctl_clear = 1'b1;
    tick();
    ctl_clear = 1'b0;
    chk("clr_state", 32'(st_w[0]), 32'd0);
    chk("clr_fault", 32'(fault_w[0]), 32'd0);

    // Timeout with one channel never good.
    pgood_raw = 32'h3;
    repeat (6) tick();
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
    chk("to_enter", 32'(st_w[0]), 32'd1);
    repeat (TMO - 1) tick();
    chk("to_before", 32'(st_w[0]), 32'd1);
    chk("to_flag_before", 32'(timeout_w[0]), 32'd0);
    tick();
    chk("to_state", 32'(st_w[0]), 32'd3);
    chk("to_fault", 32'(fault_w[0]), 32'd1);
    chk("to_flag", 32'(timeout_w[0]), 32'd1);
    ctl_clear = 1'b1;
    tick();
    ctl_clear = 1'b0;
    chk("to_clr_state", 32'(st_w[0]), 32'd0);
    chk("to_clr_fault", 32'(fault_w[0]), 32'd0);
    chk("to_clr_flag", 32'(timeout_w[0]), 32'd0);

    // Consecutive EOC toggles.
    ctl_eoc = 1'b1; tick(); chk("eoc_p1", 32'(eoc_w[0]), 32'd1);
    ctl_eoc = 1'b0; tick(); chk("eoc_p2", 32'(eoc_w[0]), 32'd1);
    ctl_eoc = 1'b1; tick(); chk("eoc_p3", 32'(eoc_w[0]), 32'd1);
    tick();         chk("eoc_end", 32'(eoc_w[0]), 32'd0);

    // Set beats clear on the same cycle.
    ctl_warn = 1'b1; ctl_clear = 1'b1;
    tick();
    chk("warn_vs_clr", 32'(warn_w[0]), 32'd1);
    chk("warn_vs_clr_state", 32'(st_w[0]), 32'd0);
    ctl_warn = 1'b0; ctl_clear = 1'b0;
    tick();
    chk("warn_sticky", 32'(warn_w[0]), 32'd1);
    ctl_fault = 1'b1; ctl_clear = 1'b1;
    tick();
    chk("fault_vs_clr", 32'(fault_w[0]), 32'd1);
    ctl_fault = 1'b0;
    tick();
    ctl_clear = 1'b0;
    chk("clr_fault2", 32'(fault_w[0]), 32'd0);
    chk("clr_warn2", 32'(warn_w[0]), 32'd0);

    // Asynchronous reset mid-operation with ctl_eoc held high.
    ctl_warn = 1'b1;
    tick();
    ctl_warn = 1'b0;
    chk("pre_rst_warn", 32'(warn_w[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_warn", 32'(warn_w[0]), 32'd0);
    chk("async_rst_bus", bus_w[0], 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel_eoc", 32'(eoc_w[0]), 32'd1);
    tick();
    chk("rel_eoc_end", 32'(eoc_w[0]), 32'd0);

    // Random phase, checked continuously against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 2) == 0) pgood_raw = 32'hFFFF_FFFF;
        else                          pgood_raw = $urandom;
      end
      ctl_start = ($urandom_range(0, 19) == 0);
      ctl_clear = ($urandom_range(0, 39) == 0);
      ctl_warn  = ($urandom_range(0, 29) == 0);
      ctl_fault = ($urandom_range(0, 49) == 0);
      ctl_eoc   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
